// File: rtl/wide_add_sequencer_if.sv
// Bundle of signals around the wide add sequencer: the operand request
// handshake, the word-serial port to the external adder, and the result
// handshake. The sequencer connects through the slave modport; the
// requester/adder side connects through the master modport.
interface wide_add_sequencer_if #(
    parameter int size  = 32,
    parameter int words = 4
);
    // operand request
    logic                    IN_VALID;
    logic                    IN_READY;
    logic [size*words-1:0]   A;
    logic [size*words-1:0]   B;
    logic                    CIN;
    logic                    SUB;
    // external combinational adder
    logic [size-1:0]         ADD_A;
    logic [size-1:0]         ADD_B;
    logic                    ADD_CIN;
    logic [size-1:0]         ADD_SUM;
    logic                    ADD_COUT;
    // result
    logic                    OUT_VALID;
    logic                    OUT_READY;
    logic [size*words-1:0]   SUM;
    logic                    COUT;
    logic                    OVF;
    logic                    BUSY;

    modport slave (
        input  IN_VALID, A, B, CIN, SUB, ADD_SUM, ADD_COUT, OUT_READY,
        output IN_READY, ADD_A, ADD_B, ADD_CIN, OUT_VALID, SUM, COUT, OVF, BUSY
    );

    modport master (
        output IN_VALID, A, B, CIN, SUB, ADD_SUM, ADD_COUT, OUT_READY,
        input  IN_READY, ADD_A, ADD_B, ADD_CIN, OUT_VALID, SUM, COUT, OVF, BUSY
    );
endinterface

// File: rtl/wide_add_sequencer.sv
// Word-serial wide adder/subtractor. Drives an external size-bit adder one
// word per cycle, LSW first, chaining the carry through a register, and
// assembles the size*words-bit result plus carry-out and signed overflow.
module wide_add_sequencer #(
    parameter int size  = 32,
    parameter int words = 4
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    wide_add_sequencer_if.slave    bus
);
    localparam int W  = size * words;
    localparam int CW = (words > 1) ? $clog2(words) : 1;
    localparam logic [CW-1:0] LAST = CW'(words - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_reg;
    logic [W-1:0]    opa_reg;
    logic [W-1:0]    opb_reg;     // B already inverted when subtracting
    logic [W-1:0]    sum_reg;
    logic [CW-1:0]   cnt_reg;
    logic            carry_reg;
    logic            cout_reg;
    logic            ovf_reg;

    logic [size-1:0] a_word [words];
    logic [size-1:0] b_word [words];

    logic run;
    logic accept;
    logic ovf_next;

    // Split the captured operands into words for the per-cycle mux.
    generate
        for (genvar gi = 0; gi < words; gi++) begin : g_word
            assign a_word[gi] = opa_reg[gi*size +: size];
            assign b_word[gi] = opb_reg[gi*size +: size];
        end
    endgenerate

    assign run    = (state_reg == RUN);
    assign accept = bus.IN_VALID & bus.IN_READY;

    // A new request can overlap the cycle in which the old result is taken.
    assign bus.IN_READY = (state_reg == IDLE) | ((state_reg == DONE) & bus.OUT_READY);

    // The adder only sees live operands during RUN; elsewhere it idles at 0.
    assign bus.ADD_A   = run ? a_word[cnt_reg] : '0;
    assign bus.ADD_B   = run ? b_word[cnt_reg] : '0;
    assign bus.ADD_CIN = run & carry_reg;

    // Signed overflow from the operand sign bits (effective B) and the top sum bit.
    assign ovf_next = (opa_reg[W-1] ~^ opb_reg[W-1]) & (opa_reg[W-1] ^ bus.ADD_SUM[size-1]);

    assign bus.OUT_VALID = (state_reg == DONE);
    assign bus.BUSY      = run;
    assign bus.SUM       = sum_reg;
    assign bus.COUT      = cout_reg;
    assign bus.OVF       = ovf_reg;

    // Sequencer FSM: capture on acceptance, one word per RUN cycle, hold result in DONE.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_reg <= IDLE;
            opa_reg   <= '0;
            opb_reg   <= '0;
            sum_reg   <= '0;
            cnt_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (accept) begin
                        opa_reg   <= bus.A;
                        opb_reg   <= bus.SUB ? ~bus.B : bus.B;
                        carry_reg <= bus.SUB ? 1'b1 : bus.CIN;
                        cnt_reg   <= '0;
                        state_reg <= RUN;
                    end else if (state_reg == DONE && bus.OUT_READY) begin
                        state_reg <= IDLE;
                    end
                end
                RUN: begin
                    sum_reg[cnt_reg*size +: size] <= bus.ADD_SUM;
                    carry_reg <= bus.ADD_COUT;
                    if (cnt_reg == LAST) begin
                        cout_reg  <= bus.ADD_COUT;
                        ovf_reg   <= ovf_next;
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wide_add_sequencer.sv
// Scoreboard bench for wide_add_sequencer (size=32, words=4): directed
// vectors push expected results, a monitor pops on each output handshake.
module tb_wide_add_sequencer;
    localparam int SZ = 32;
    localparam int WD = 4;

    typedef struct packed {
        logic [127:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t exp_q[$];

    wide_add_sequencer_if #(.size(SZ), .words(WD)) bus ();

    wide_add_sequencer #(.size(SZ), .words(WD)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // External combinational adder model.
    assign {bus.ADD_COUT, bus.ADD_SUM} = {1'b0, bus.ADD_A} + {1'b0, bus.ADD_B} + {32'd0, bus.ADD_CIN};

    function automatic void check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", name, got, exp);
    endfunction

    // Monitor: pops and compares whenever a result handshake occurs.
    always @(negedge clk) begin
        if (rst_n && bus.OUT_VALID && bus.OUT_READY) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 128'd1, 128'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sum", bus.SUM, e.sum);
                check("cout", {127'd0, bus.COUT}, {127'd0, e.cout});
                check("ovf", {127'd0, bus.OVF}, {127'd0, e.ovf});
                $display("result sum=%h cout=%0d ovf=%0d", bus.SUM, bus.COUT, bus.OVF);
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Issue one request; returns just after the acceptance edge.
    task automatic do_op(input logic [127:0] a, input logic [127:0] b, input logic cin,
                         input logic sub, input logic [127:0] es, input logic ec,
                         input logic eo, input bit push, output int acc_cyc);
        int t;
        bus.A = a; bus.B = b; bus.CIN = cin; bus.SUB = sub; bus.IN_VALID = 1'b1;
        t = 0;
        acc_cyc = -1;
        forever begin
            @(negedge clk);
            if (bus.IN_READY) break;
            t++;
            if (t > 50) begin
                check("accept_timeout", 128'd1, 128'd0);
                bus.IN_VALID = 1'b0;
                return;
            end
        end
        @(posedge clk);
        if (push) exp_q.push_back('{sum: es, cout: ec, ovf: eo});
        #1;
        acc_cyc = cyc;
        bus.IN_VALID = 1'b0;
        $display("issue a=%h b=%h cin=%0d sub=%0d", a, b, cin, sub);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            if (!bus.BUSY && !bus.OUT_VALID) return;
            @(posedge clk); #1;
        end
        check("idle_timeout", 128'd1, 128'd0);
    endtask

    initial begin
        logic [127:0] ones, maxp, minn;
        logic         cin_seq [4];
        int           acc0, acc1, acc2, lat;
        ones = '1;
        maxp = {1'b0, {127{1'b1}}};
        minn = {1'b1, 127'd0};

        bus.IN_VALID = 0; bus.A = '0; bus.B = '0; bus.CIN = 0; bus.SUB = 0;
        bus.OUT_READY = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {127'd0, bus.IN_READY}, 128'd1);
        check("rst_outs", {bus.OUT_VALID, bus.BUSY, bus.COUT, bus.OVF, bus.ADD_CIN}, 128'd0);
        check("rst_sum", bus.SUM, 128'd0);
        check("rst_add", {bus.ADD_A, bus.ADD_B}, 128'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Carry ripple with latency and carry-chain observation
        do_op(ones, 128'd1, 1'b0, 1'b0, 128'd0, 1'b1, 1'b0, 1, acc0);
        cin_seq[0] = bus.ADD_CIN;
        lat = -1;
        for (int i = 1; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.OUT_VALID) begin lat = i; break; end
            if (i < 4) cin_seq[i] = bus.ADD_CIN;
        end
        check("latency", 128'(lat), 128'd4);
        check("add_cin_seq", {124'd0, cin_seq[0], cin_seq[1], cin_seq[2], cin_seq[3]}, 128'b0111);

        // Signed overflow
        do_op(maxp, 128'd1, 1'b0, 1'b0, minn, 1'b0, 1'b1, 1, acc0);
        do_op(minn, minn, 1'b0, 1'b0, 128'd0, 1'b1, 1'b1, 1, acc0);

        // Subtract (CIN ignored)
        do_op(128'd5, 128'd7, 1'b1, 1'b1, {{127{1'b1}}, 1'b0}, 1'b0, 1'b0, 1, acc0);
        do_op(128'd7, 128'd5, 1'b0, 1'b1, 128'd2, 1'b1, 1'b0, 1, acc0);

        // Backpressure
        wait_idle();
        bus.OUT_READY = 1'b0;
        do_op(128'h10, 128'h20, 1'b0, 1'b0, 128'h30, 1'b0, 1'b0, 1, acc0);
        for (int i = 0; i < 20 && !bus.OUT_VALID; i++) begin
            @(posedge clk); #1;
        end
        check("bp_valid_rise", {127'd0, bus.OUT_VALID}, 128'd1);
        bus.IN_VALID = 1'b1; bus.A = ones; bus.B = ones;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_sum", bus.SUM, 128'h30);
            check("bp_flags", {bus.OUT_VALID, bus.IN_READY, bus.COUT, bus.OVF}, 128'b1000);
            check("bp_add", {bus.ADD_A, bus.ADD_B, 31'd0, bus.ADD_CIN}, 128'd0);
        end
        bus.IN_VALID = 1'b0;
        bus.OUT_READY = 1'b1;
        @(posedge clk); #1;
        check("bp_release", {127'd0, bus.OUT_VALID}, 128'd0);

        // Back-to-back
        do_op(128'd1, 128'd2, 1'b1, 1'b0, 128'd4, 1'b0, 1'b0, 1, acc0);
        do_op(128'h1_FFFF_FFFF, 128'd1, 1'b0, 1'b0, 128'h2_0000_0000, 1'b0, 1'b0, 1, acc1);
        do_op(128'd3, 128'd3, 1'b0, 1'b1, 128'd0, 1'b1, 1'b0, 1, acc2);
        check("b2b_gap1", 128'(acc1 - acc0), 128'd5);
        check("b2b_gap2", 128'(acc2 - acc1), 128'd5);

        // Reset mid-operation (no result expected)
        wait_idle();
        do_op(ones, ones, 1'b0, 1'b0, 128'd0, 1'b0, 1'b0, 0, acc0);
        repeat (2) begin @(posedge clk); #1; end
        check("mid_busy", {127'd0, bus.BUSY}, 128'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_in_ready", {127'd0, bus.IN_READY}, 128'd1);
        check("abort_outs", {bus.OUT_VALID, bus.BUSY, bus.COUT, bus.OVF, bus.ADD_CIN}, 128'd0);
        check("abort_sum", bus.SUM, 128'd0);
        check("abort_add", {bus.ADD_A, bus.ADD_B}, 128'd0);
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.OUT_VALID) check("abort_valid", 128'd1, 128'd0);
        end

        // Fresh operation after abort
        do_op(128'hFFFF_FFFF, 128'd1, 1'b0, 1'b0, 128'h1_0000_0000, 1'b0, 1'b0, 1, acc0);
        wait_idle();
        repeat (2) @(posedge clk);
        check("queue_drained", 128'(exp_q.size()), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/wide_add_sequencer.md
# wide_add_sequencer

Multi-cycle sequencer that adds two `size*words`-bit operands by driving an external combinational `size`-bit adder one word per cycle, least-significant word first, and chaining the carry through a register. It sits directly around the ALU's carry-increment adder: upstream it supplies the adder's A/B/CIN, and downstream it consumes the adder's SUM/COUT. Operands arrive on a valid/ready input handshake; the assembled wide result, carry and signed overflow leave on a valid/ready output handshake.

## Interface
- `size`, 32: width of the external adder and of one operand word.
- `words`, 4: number of words per operand; legal range is 1 or more.
- `CLK`  in  1  clock; all state changes on the rising edge.
- `RST_N`  in  1  synchronous, active-low reset.
- `IN_VALID`  in  1  operand request valid.
- `IN_READY`  out  1  block accepts the operand request this cycle.
- `A`  in  size*words  operand A.
- `B`  in  size*words  operand B.
- `CIN`  in  1  carry-in for add; ignored when `SUB`=1.
- `SUB`  in  1  1 selects A + ~B + 1; 0 selects A + B + CIN.
- `ADD_A`  out  size  current A word presented to the external adder.
- `ADD_B`  out  size  current B word presented to the adder, already inverted when subtracting.
- `ADD_CIN`  out  1  carry into the current word.
- `ADD_SUM`  in  size  adder sum for the current word; combinational in the same cycle.
- `ADD_COUT`  in  1  adder carry-out for the current word.
- `OUT_VALID`  out  1  result valid.
- `OUT_READY`  in  1  consumer takes the result.
- `SUM`  out  size*words  wide result.
- `COUT`  out  1  carry-out of the most-significant word.
- `OVF`  out  1  two's-complement overflow of the wide operation.
- `BUSY`  out  1  high while in the RUN state.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- Internal registers:
  - `opA` and `opB` capture A and, for `opB`, B or ~B depending on SUB; both are `size*words` wide.
  - The word counter `cnt` is max(1, ceil(log2(words))) bits wide.
  - The carry register is `carry`.
- Acceptance: the transfer happens when IN_VALID && IN_READY.
- IN_READY = (state==IDLE) | (state==DONE & OUT_READY).
- On acceptance, on the same edge:
  - Capture opA = A.
  - Capture opB = SUB ? ~B : B.
  - Set carry = SUB ? 1 : CIN.
  - Set cnt = 0.
  - Go to RUN.
- In RUN, the adder outputs are driven as follows:
  - ADD_A = opA word[cnt].
  - ADD_B = opB word[cnt].
  - ADD_CIN = carry.
- In RUN, on each edge:
  - SUM word[cnt] <= ADD_SUM.
  - carry <= ADD_COUT.
  - cnt <= cnt+1.
- Last word of RUN (cnt==words-1):
  - COUT <= ADD_COUT.
  - OVF <= (opA_msb ~^ opB_msb) & (opA_msb ^ ADD_SUM[size-1]). This uses the effective, already-inverted B. Overflow is computed by this block, not taken from the adder.
  - The FSM goes to DONE.
- In IDLE and DONE, ADD_A, ADD_B and ADD_CIN are driven to 0.
- In DONE:
  - OUT_VALID=1.
  - SUM, COUT and OVF are held stable until OUT_READY.
  - If OUT_READY and there is no acceptance, the FSM goes to IDLE.
  - If OUT_READY and there is an acceptance on the same cycle, the FSM goes straight to RUN.
- SUM is meaningful only while OUT_VALID=1. During RUN it is partially overwritten.
- words=1: RUN lasts one cycle; the counter never increments past 0.

## Timing
- Reset, with RST_N=0 sampled on an edge, forces:
  - state=IDLE and cnt=0.
  - carry=0.
  - OUT_VALID=0 and BUSY=0.
  - SUM=0, COUT=0 and OVF=0.
  - ADD_A=0, ADD_B=0 and ADD_CIN=0.
  - IN_READY=1 in the cycle after reset.
- Reset mid-RUN or in DONE aborts the operation. The pending result is discarded and OUT_VALID is never raised for it.
- Latency: an operation accepted on edge k gives OUT_VALID=1 from cycle k+words onward, i.e. after words RUN cycles.
- Throughput with OUT_READY held high: one operation every words+1 cycles, because acceptance overlaps the DONE cycle.
- Backpressure: OUT_VALID stays high and the outputs are frozen for any number of cycles with OUT_READY=0. IN_READY stays 0 during that time.
- A and B are sampled only on the acceptance edge; later changes have no effect.
- The critical path is from ADD_A/ADD_B through the external adder to ADD_SUM/ADD_COUT, then into the SUM and carry registers, all within one cycle.
- Simultaneous events:
  - IN_VALID while in RUN is ignored and is not accepted.
  - OUT_READY while OUT_VALID=0 has no effect.

## Test plan
All scenarios use size=32 and words=4, i.e. 128-bit operands.
- Carry ripple: A=all-ones, B=1, CIN=0, SUB=0 -> SUM=0, COUT=1, OVF=0. OUT_VALID rises exactly 4 cycles after acceptance. ADD_CIN reads 0,1,1,1 across the RUN cycles.
- Signed overflow: A=0x7FFF…FFFF, B=1 -> SUM=0x8000…0000, COUT=0, OVF=1. Also A=0x8000…0, B=0x8000…0 -> SUM=0, COUT=1, OVF=1.
- Subtract: SUB=1, A=5, B=7, CIN=1 (ignored) -> SUM=0xFFFF…FFFE, COUT=0, OVF=0. Also SUB=1, A=7, B=5 -> SUM=2, COUT=1.
- Backpressure: OUT_READY=0 for 10 cycles after OUT_VALID rises -> SUM, COUT and OVF are unchanged, IN_READY=0 and ADD_* =0. With OUT_READY=1 the next cycle, OUT_VALID drops.
- Back-to-back: IN_VALID and OUT_READY held high with three operand pairs -> acceptances exactly 5 cycles apart and each result correct.
- Reset mid-operation: assert RST_N=0 for one edge when cnt=2 -> next cycle all outputs are 0 and IN_READY=1, and no OUT_VALID appears for the aborted operation. A fresh operation afterwards completes correctly.
